// File: rtl/uga_dyna_pkg.sv
// rtl/uga_dyna_pkg.sv - shared Dynamixel packet types, constants and checksum helper
package uga_dyna_pkg;

  localparam logic [7:0] DYNA_PREAMBLE    = 8'hFF;
  localparam int         STATUS_MAX_PARAM = 4;

  typedef enum logic [2:0] {
    S_HDR1,
    S_HDR2,
    S_ID,
    S_LEN,
    S_ERR,
    S_PARAM,
    S_CHK
  } rx_state_t;

  // 80-bit status packet; param[0] is the first parameter byte on the wire
  typedef struct packed {
    logic [15:0]                       preamble;
    logic [7:0]                        id;
    logic [7:0]                        length;
    logic [7:0]                        error;
    logic [STATUS_MAX_PARAM-1:0][7:0]  param;
    logic [7:0]                        checksum;
  } status_packet_t;

  // Unused params are zero in an assembled packet, so summing every slot is exact
  function automatic logic [7:0] dyna_status_checksum(input status_packet_t p);
    logic [7:0] s;
    s = p.id + p.length + p.error;
    for (int i = 0; i < STATUS_MAX_PARAM; i++) begin
      s = s + p.param[i];
    end
    return ~s;
  endfunction

endpackage

// File: rtl/uga_dyna_byte_timer.sv
// rtl/uga_dyna_byte_timer.sv - saturating inter-byte idle counter with expiry strobe
module uga_dyna_byte_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_expire
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  LIMIT    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  LIMIT_M1 = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // Count idle cycles, clearing on request and holding at the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (r_count != LIMIT) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expiry fires on the edge where the count reaches the limit; a clear wins
  assign o_expire = !i_clear && (r_count == LIMIT_M1);

endmodule

// File: rtl/uga_dyna_status_rx.sv
// rtl/uga_dyna_status_rx.sv - Dynamixel status packet parser with length/checksum/id/timeout checks
module uga_dyna_status_rx
  import uga_dyna_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int MAX_PARAM      = STATUS_MAX_PARAM
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  input  logic [7:0]     expected_id,
  output status_packet_t pkt,
  output logic           pkt_valid,
  output logic           chk_err,
  output logic           len_err,
  output logic           id_err,
  output logic           timeout,
  output logic           busy
);

  localparam int              PIDX_W  = $clog2(MAX_PARAM + 1);
  localparam logic [7:0]      LEN_MIN = 8'd2;
  localparam logic [7:0]      LEN_MAX = 8'(MAX_PARAM + 2);

  rx_state_t                         r_state;
  rx_state_t                         w_state_nxt;
  logic [7:0]                        r_id;
  logic [7:0]                        r_len;
  logic [7:0]                        r_err;
  logic [7:0]                        r_sum;
  logic [STATUS_MAX_PARAM-1:0][7:0]  r_param;
  logic [PIDX_W-1:0]                 r_idx;
  logic [PIDX_W-1:0]                 r_nparam;
  status_packet_t                    r_pkt;
  logic                              r_pkt_valid;
  logic                              r_chk_err;
  logic                              r_len_err;
  logic                              r_id_err;
  logic                              r_timeout;

  logic                              w_tmr_clear;
  logic                              w_expire;
  logic                              w_len_ok;
  logic                              w_chk_ok;
  logic [PIDX_W-1:0]                 w_idx_inc;
  logic                              w_pkt_valid_nxt;
  logic                              w_chk_err_nxt;
  logic                              w_len_err_nxt;
  logic                              w_id_err_nxt;
  logic                              w_timeout_nxt;

  assign w_tmr_clear = rx_valid || (r_state == S_HDR1);
  assign w_len_ok    = (rx_data >= LEN_MIN) && (rx_data <= LEN_MAX);
  assign w_chk_ok    = (rx_data == ~r_sum);
  assign w_idx_inc   = r_idx + PIDX_W'(1);

  uga_dyna_byte_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_byte_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_tmr_clear),
    .o_expire (w_expire)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_HDR1;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and pulse decode; a byte in the expiry cycle takes priority over the timeout
  always_comb begin
    w_state_nxt     = r_state;
    w_pkt_valid_nxt = 1'b0;
    w_chk_err_nxt   = 1'b0;
    w_len_err_nxt   = 1'b0;
    w_id_err_nxt    = 1'b0;
    w_timeout_nxt   = 1'b0;
    if (rx_valid) begin
      case (r_state)
        S_HDR1: begin
          if (rx_data == DYNA_PREAMBLE) w_state_nxt = S_HDR2;
        end
        S_HDR2: begin
          w_state_nxt = (rx_data == DYNA_PREAMBLE) ? S_ID : S_HDR1;
        end
        S_ID: begin
          if (rx_data != DYNA_PREAMBLE) w_state_nxt = S_LEN;
        end
        S_LEN: begin
          if (w_len_ok) begin
            w_state_nxt = S_ERR;
          end else begin
            w_len_err_nxt = 1'b1;
            w_state_nxt   = S_HDR1;
          end
        end
        S_ERR: begin
          w_state_nxt = (r_nparam != '0) ? S_PARAM : S_CHK;
        end
        S_PARAM: begin
          if (w_idx_inc == r_nparam) w_state_nxt = S_CHK;
        end
        S_CHK: begin
          w_state_nxt = S_HDR1;
          if (w_chk_ok) begin
            w_pkt_valid_nxt = 1'b1;
            w_id_err_nxt    = (r_id != expected_id);
          end else begin
            w_chk_err_nxt = 1'b1;
          end
        end
        default: w_state_nxt = S_HDR1;
      endcase
    end else if (w_expire) begin
      w_timeout_nxt = 1'b1;
      w_state_nxt   = S_HDR1;
    end
  end

  // Register the one-cycle status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_valid <= 1'b0;
      r_chk_err   <= 1'b0;
      r_len_err   <= 1'b0;
      r_id_err    <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_pkt_valid <= w_pkt_valid_nxt;
      r_chk_err   <= w_chk_err_nxt;
      r_len_err   <= w_len_err_nxt;
      r_id_err    <= w_id_err_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  // Field capture, running checksum and packet publication on a good checksum
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id     <= '0;
      r_len    <= '0;
      r_err    <= '0;
      r_sum    <= '0;
      r_param  <= '0;
      r_idx    <= '0;
      r_nparam <= '0;
      r_pkt    <= '0;
    end else if (rx_valid) begin
      case (r_state)
        S_ID: begin
          if (rx_data != DYNA_PREAMBLE) begin
            r_id  <= rx_data;
            r_sum <= rx_data;
          end
        end
        S_LEN: begin
          if (w_len_ok) begin
            r_len    <= rx_data;
            r_sum    <= r_sum + rx_data;
            r_nparam <= PIDX_W'(rx_data - LEN_MIN);
          end
        end
        S_ERR: begin
          r_err   <= rx_data;
          r_sum   <= r_sum + rx_data;
          r_param <= '0;
          r_idx   <= '0;
        end
        S_PARAM: begin
          for (int i = 0; i < STATUS_MAX_PARAM; i++) begin
            if (r_idx == PIDX_W'(i)) r_param[i] <= rx_data;
          end
          r_sum <= r_sum + rx_data;
          r_idx <= w_idx_inc;
        end
        S_CHK: begin
          if (w_chk_ok) begin
            r_pkt.preamble <= {DYNA_PREAMBLE, DYNA_PREAMBLE};
            r_pkt.id       <= r_id;
            r_pkt.length   <= r_len;
            r_pkt.error    <= r_err;
            r_pkt.param    <= r_param;
            r_pkt.checksum <= rx_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign pkt       = r_pkt;
  assign pkt_valid = r_pkt_valid;
  assign chk_err   = r_chk_err;
  assign len_err   = r_len_err;
  assign id_err    = r_id_err;
  assign timeout   = r_timeout;
  assign busy      = (r_state != S_HDR1);

endmodule

// File: doc/uga_dyna_status_rx.md
Name: uga_dyna_status_rx

Overview:
- Receive-side parser for Dynamixel status packets. Sits directly downstream of the UART RX byte stream and upstream of the servo controller FSM.
- Assembles bytes into a status_packet_t and checks the length, checksum and ID.
- Delivers each packet with a one-cycle valid pulse. Flags malformed, corrupt or stalled packets.

Parameters:
- TIMEOUT_CYCLES, 100000: maximum idle clk cycles allowed between two bytes of a packet before it is aborted.
- MAX_PARAM, 4: maximum number of status parameters; must match the param array depth of status_packet_t.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid; no backpressure.
- expected_id  in  8  ID of the servo currently addressed.
- pkt  out  80  last accepted packet, typed status_packet_t.
- pkt_valid  out  1  one-cycle pulse, pkt updated.
- chk_err  out  1  one-cycle pulse, checksum mismatch.
- len_err  out  1  one-cycle pulse, length field out of range.
- id_err  out  1  one-cycle pulse, valid packet but id != expected_id.
- timeout  out  1  one-cycle pulse, inter-byte timeout mid-packet.
- busy  out  1  high while any state other than S_HDR1 is active.

Behaviour:
- Reset: state=S_HDR1; pkt=0; all pulses=0; busy=0; byte timer=0; internal running sum=0; param index=0.
- FSM advances only on cycles where rx_valid=1. States:
  - S_HDR1: byte 0xFF -> S_HDR2; any other byte ignored.
  - S_HDR2: byte 0xFF -> S_ID; otherwise -> S_HDR1.
  - S_ID: 0xFF stays in S_ID (extra preamble tolerated, ID 0xFF illegal). Otherwise latch id, sum=id, -> S_LEN.
  - S_LEN: accepted range is 2 <= L <= MAX_PARAM+2.
    - In range: latch L, sum+=L, N=L-2, -> S_ERR.
    - Out of range: len_err pulse, -> S_HDR1.
  - S_ERR: latch error byte, sum+=byte, clear param array to 0. Then -> S_PARAM if N>0, else -> S_CHK.
  - S_PARAM: store byte at param[idx], sum+=byte, idx++. When idx reaches N -> S_CHK.
  - S_CHK: compare byte with ~sum.
    - Equal: one cycle later pkt is updated (preamble=16'hFFFF, unused params=0) and pkt_valid pulses. id_err pulses in the same cycle if id != expected_id; pkt_valid still asserts.
    - Not equal: chk_err pulse one cycle later; pkt unchanged.
    - Both cases -> S_HDR1.
- Arithmetic: sum is 8 bits, modulo 256. The expected checksum is bit-identical to dyna_status_checksum applied to the assembled packet.
- Latency: all pulses register one clk after the rx_valid cycle of the final/offending byte. Pulses are mutually exclusive, except pkt_valid+id_err.
- Timer:
  - Clears on every rx_valid and whenever the state is S_HDR1.
  - Otherwise increments and saturates at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES outside S_HDR1: timeout pulse, -> S_HDR1, partial data discarded, pkt unchanged.
  - If rx_valid arrives in the same cycle as expiry, the byte wins: it is processed and the timer clears.
- Back-to-back packets: a byte arriving the cycle right after a checksum byte is handled in S_HDR1 with no loss.
- Reset mid-packet: immediate return to reset values; no pulse is generated.

Decomposition:
- uga_dyna_pkg gains:
  - rx_state_t enum {S_HDR1,S_HDR2,S_ID,S_LEN,S_ERR,S_PARAM,S_CHK};
  - localparam DYNA_PREAMBLE=8'hFF;
  - localparam STATUS_MAX_PARAM=4.
- Reuse status_packet_t and dyna_status_checksum from the package; do not duplicate them.
- One sub-module, uga_dyna_byte_timer: saturating counter with clear/expire; parameter TIMEOUT_CYCLES.

Test Plan:
- Ping reply FF FF 01 02 00 FC with expected_id=01 -> pkt_valid one clk after the last byte; id=01, length=02, error=00, params=0, checksum=FC; no error pulses.
- Read reply FF FF 01 04 00 20 01 D9 -> pkt_valid; param[0]=20, param[1]=01, param[2..3]=00.
- Same read reply with last byte D8 -> chk_err only; pkt keeps its previous value.
- Length error: FF FF 01 07 ... -> len_err after the 07 byte; a following FF FF 01 02 00 FC is accepted normally.
- Extra preamble FF FF FF 01 02 00 FC -> accepted. FF FF 03 02 00 FA with expected_id=01 -> pkt_valid plus id_err.
- Stalls:
  - TIMEOUT_CYCLES=16, send FF FF 01, then idle -> timeout pulse 16 clk after the 01 byte, busy drops.
  - Byte arriving exactly at expiry -> no timeout.
  - rst asserted mid-packet -> all outputs back to zero next clk, and the following good packet is accepted.
